// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FIX,
    DONE
  } state_t;

  // Which result path the DONE state publishes.
  typedef enum logic [1:0] {
    OP_MULT,
    OP_DIV,
    OP_DZ
  } op_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it did not go negative.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvs,
  output logic [31:0] rem_nxt,
  output logic [31:0] quo_nxt
);

  logic [32:0] part;
  logic [32:0] trial;

  // A 33-bit partial remainder is needed because |b| can be 2^31.
  always_comb begin
    part  = {rem, quo[31]};
    trial = part - {1'b0, dvs};
    if (trial[32]) begin
      rem_nxt = part[31:0];
      quo_nxt = {quo[30:0], 1'b0};
    end else begin
      rem_nxt = trial[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit answering the control unit's
// MultCtrl/DivCtrl start pulses; results are held on hi/lo until the next done.
//
// state | meaning
// IDLE  | waiting for start_mult/start_div; new start allowed during done pulse
// MULT  | 32 radix-2 Booth iterations on {acc, mq, qm1}
// DIV   | 32 restoring-division iterations on |a| / |b|
// FIX   | apply result signs to quotient and remainder
// DONE  | publish hi/lo (or flag divide-by-zero), pulse done next cycle
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t           state;
  op_t              op;
  logic [CNT_W-1:0] cnt;

  // Multiply: acc is the running high half, mq the multiplier/low half.
  // Divide: mq holds the dividend shifting out / quotient shifting in.
  logic [31:0] acc;
  logic [31:0] mq;
  logic        qm1;
  logic [31:0] mreg;  // multiplicand (a) or divisor magnitude (|b|)
  logic [31:0] rem;
  logic        neg_q;
  logic        neg_r;

  logic [32:0] booth_sum;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  // Booth add/subtract, sign-extended to 33 bits so the -2^31 multiplicand
  // cannot overflow before the arithmetic shift.
  always_comb begin
    booth_sum = {acc[31], acc};
    case ({mq[0], qm1})
      2'b01:   booth_sum = {acc[31], acc} + {mreg[31], mreg};
      2'b10:   booth_sum = {acc[31], acc} - {mreg[31], mreg};
      default: booth_sum = {acc[31], acc};
    endcase
  end

  div_step u_div_step (
    .rem     (rem),
    .quo     (mq),
    .dvs     (mreg),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Sequencer with registered busy/done/div_zero and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op       <= OP_MULT;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      qm1      <= 1'b0;
      mreg     <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            acc   <= '0;
            mq    <= b;
            qm1   <= 1'b0;
            mreg  <= a;
            op    <= OP_MULT;
            busy  <= 1'b1;
            state <= MULT;
          end else if (start_div) begin
            busy <= 1'b1;
            if (b == '0) begin
              op    <= OP_DZ;
              state <= DONE;
            end else begin
              rem   <= '0;
              mq    <= abs32(a);
              mreg  <= abs32(b);
              neg_q <= a[31] ^ b[31];
              neg_r <= a[31];
              op    <= OP_DIV;
              state <= DIV;
            end
          end
        end
        MULT: begin
          acc <= booth_sum[32:1];
          mq  <= {booth_sum[0], mq[31:1]};
          qm1 <= mq[0];
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          mq  <= quo_nxt;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          // Truncating division: quotient sign from a^b, remainder follows a.
          mq    <= neg_q ? (~mq + 32'd1) : mq;
          rem   <= neg_r ? (~rem + 32'd1) : rem;
          state <= DONE;
        end
        DONE: begin
          case (op)
            OP_MULT: begin
              hi <= acc;
              lo <= mq;
            end
            OP_DIV: begin
              hi <= rem;
              lo <= mq;
            end
            default: div_zero <= 1'b1;
          endcase
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_div;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] ehi;
    logic [31:0] elo;
    bit          edz;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Issue one operation at the current negedge and wait (bounded) for done.
  // Returns at the negedge inside the done cycle unless check_pulse is set.
  task automatic do_op(input bit is_div, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ehi, input logic [31:0] elo, input bit edz,
                       input bit check_pulse, input string nm);
    int n;
    int lat;
    bit busy_ok;
    start_mult = !is_div;
    start_div  = is_div;
    a = av;
    b = bv;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = edz ? 1 : (is_div ? 34 : 33);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({nm, " done"}, 64'(done), 64'd1);
    chk({nm, " latency"}, 64'(n), 64'(lat));
    chk({nm, " busy_during"}, 64'(busy_ok), 64'd1);
    chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
    chk({nm, " div_zero"}, 64'(div_zero), 64'(edz));
    chk({nm, " hi"}, 64'(hi), 64'(ehi));
    chk({nm, " lo"}, 64'(lo), 64'(elo));
    if (check_pulse) begin
      @(negedge clk);
      chk({nm, " done_pulse"}, 64'({done, div_zero}), 64'd0);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic void model(input bit is_div, input logic [31:0] av, input logic [31:0] bv,
                                inout logic [31:0] mh, inout logic [31:0] ml, output bit dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    dz = 1'b0;
    if (!is_div) begin
      p  = sa * sb;
      mh = p[63:32];
      ml = p[31:0];
    end else if (bv == 32'd0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      mh = r[31:0];
      ml = q[31:0];
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h80000000;
      1: return 32'h7FFFFFFF;
      2: return 32'hFFFFFFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[$];

  initial begin
    int n;
    bit seen;
    logic [31:0] mh, ml, ra, rb;
    bit dz, isd;

    vecs = '{
      '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0},
      '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0},
      '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0},
      '{1'b1, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0},
      '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0},
      '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0},
      '{1'b0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0},
      '{1'b1, 32'h00000005, 32'h00000000, 32'hC0000000, 32'h80000000, 1'b1},
      '{1'b1, 32'h00000007, 32'h00000007, 32'h00000000, 32'h00000001, 1'b0},
      '{1'b1, 32'h00000003, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0},
      '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0}
    };

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      do_op(vecs[i].is_div, vecs[i].av, vecs[i].bv, vecs[i].ehi, vecs[i].elo,
            vecs[i].edz, 1'b1, $sformatf("vec%0d", i));

    // Back-to-back: next start issued during the done cycle.
    do_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, "b2b_mult");
    do_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1, "b2b_div");

    // start_div pulsed mid-multiply must be ignored.
    start_mult = 1'b1;
    a = 32'd12345;
    b = 32'hFFFFFF00;
    @(negedge clk);
    start_mult = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      if (n == 10) begin
        start_div = 1'b1;
        a = 32'd9;
        b = 32'd0;
      end else begin
        start_div = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start_div = 1'b0;
    chk("ignore latency", 64'(n), 64'd33);
    chk("ignore hi", 64'(hi), 64'hFFFFFFFF);
    chk("ignore lo", 64'(lo), 64'hFFCFC700);
    chk("ignore div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    chk("ignore no_extra_done", 64'(done), 64'd0);

    // Reset in the middle of a multiply aborts with no done.
    start_mult = 1'b1;
    a = 32'd77;
    b = 32'd99;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort no_done", 64'(seen), 64'd0);

    // Random operations against the reference model.
    mh = 32'd0;
    ml = 32'd0;
    for (int k = 0; k < 40; k++) begin
      isd = $urandom_range(0, 1);
      ra = pick();
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
      model(isd, ra, rb, mh, ml, dz);
      do_op(isd, ra, rb, mh, ml, dz, k[0], $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
